// File: rtl/seven_seg_scan_controller.sv
// Four-digit common-anode 7-segment scan controller with blanking and tear-free frame commits.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses zero digits above the most significant non-zero digit.
module seven_seg_scan_controller #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] digits_in,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int unsigned    CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(REFRESH_DIV - 2);
    localparam logic [CNT_W-1:0] CNT_BLK = CNT_W'(BLANK_CYCLES);

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = 7'b0111111;
        endcase
        return pat;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      pending_q, pending_d;
    logic             pending_full_q, pending_full_d;
    logic [15:0]      display_q, display_d;
    logic             load_ready_q, load_ready_d;
    logic             frame_tick_q, frame_tick_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;

    logic             slot_end_s;
    logic             commit_s;
    logic             accept_s;
    logic             blank_s;
    logic             suppress_s;
    logic [3:0]       cur_nib_s;

    // Scan timing, handshake, frame commit and next-cycle pin values.
    always_comb begin
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        display_d      = display_q;
        seg_d          = SEG_OFF;
        an_d           = AN_OFF;
        suppress_s     = 1'b0;
        cur_nib_s      = 4'd0;

        slot_end_s = (cnt_q == CNT_MAX);
        commit_s   = slot_end_s && (idx_q == 2'd3);
        accept_s   = load_valid && load_ready_q;

        if (slot_end_s) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Commit drains the old pending value first; acceptance only happens when pending was empty.
        if (commit_s && pending_full_q) begin
            display_d      = pending_q;
            pending_full_d = 1'b0;
        end else begin
            display_d = display_q;
        end

        if (accept_s) begin
            pending_d      = digits_in;
            pending_full_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end

        load_ready_d = !pending_full_d;
        // Look one cycle ahead so the registered pulse lands on the commit cycle itself.
        frame_tick_d = (idx_q == 2'd3) && (cnt_q == CNT_PRE);

        case (idx_q)
            2'd0:    cur_nib_s = display_q[3:0];
            2'd1:    cur_nib_s = display_q[7:4];
            2'd2:    cur_nib_s = display_q[11:8];
            2'd3:    cur_nib_s = display_q[15:12];
            default: cur_nib_s = 4'd0;
        endcase

`ifdef LEADING_ZERO_BLANK_EN
        case (idx_q)
            2'd1:    suppress_s = (display_q[15:4] == 12'd0);
            2'd2:    suppress_s = (display_q[15:8] == 8'd0);
            2'd3:    suppress_s = (display_q[15:12] == 4'd0);
            default: suppress_s = 1'b0;
        endcase
`else
        suppress_s = 1'b0;
`endif

        blank_s = (cnt_q < CNT_BLK);

        if (blank_s || suppress_s) begin
            seg_d = SEG_OFF;
            an_d  = AN_OFF;
        end else begin
            seg_d = seg_decode(cur_nib_s);
            an_d  = ~(4'b0001 << idx_q);
        end
    end

    // State and output registers; reset darkens the display without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            idx_q          <= 2'd0;
            pending_q      <= 16'd0;
            pending_full_q <= 1'b0;
            display_q      <= 16'd0;
            load_ready_q   <= 1'b1;
            frame_tick_q   <= 1'b0;
            seg_q          <= SEG_OFF;
            an_q           <= AN_OFF;
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            display_q      <= display_d;
            load_ready_q   <= load_ready_d;
            frame_tick_q   <= frame_tick_d;
            seg_q          <= seg_d;
            an_q           <= an_d;
        end
    end

    assign load_ready = load_ready_q;
    assign frame_tick = frame_tick_q;
    assign seg        = seg_q;
    assign an         = an_q;

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Randomized bench for seven_seg_scan_controller against a frame-position reference model.
module tb_seven_seg_scan_controller;

    localparam int unsigned RD = 4;
    localparam int unsigned BC = 1;
    localparam int unsigned FRAME = 4 * RD;

    logic        clk;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] digits_in;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    seven_seg_scan_controller #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .digits_in  (digits_in),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [6:0]  dec_tbl [16];
    int unsigned mdl_n;
    logic [15:0] mdl_disp;
    logic [15:0] mdl_pend[$];

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, mdl_n);
    endtask

    task automatic model_reset();
        mdl_n    = 0;
        mdl_disp = 16'h0000;
        mdl_pend.delete();
    endtask

    // One clock: predict outputs from the frame position, advance the model, compare after the edge.
    task automatic step(input logic v, input logic [15:0] d, output logic acc);
        int unsigned pos, dig, off;
        logic [3:0]  nib;
        logic [6:0]  e_seg;
        logic [3:0]  e_an;
        bit          lit;
        bit          e_tick;
        bit          e_ready;
        load_valid = v;
        digits_in  = d;
        pos = mdl_n % FRAME;
        dig = pos / RD;
        off = pos % RD;
        nib = 4'(mdl_disp >> (4 * dig));
        lit = (off >= BC);
`ifdef LEADING_ZERO_BLANK_EN
        if (dig != 0 && (mdl_disp >> (4 * dig)) == 16'h0000) lit = 1'b0;
`endif
        e_an  = lit ? ~(4'(1) << dig) : 4'hF;
        e_seg = lit ? dec_tbl[nib] : 7'h7F;
        acc = v && (mdl_pend.size() == 0);
        if (pos == FRAME - 1 && mdl_pend.size() != 0) mdl_disp = mdl_pend.pop_front();
        if (acc) mdl_pend.push_back(d);
        mdl_n++;
        e_tick  = ((mdl_n % FRAME) == FRAME - 1);
        e_ready = (mdl_pend.size() == 0);
        @(posedge clk);
        #1;
        check_val("an", {12'd0, an}, {12'd0, e_an});
        check_val("seg", {9'd0, seg}, {9'd0, e_seg});
        check_val("frame_tick", {15'd0, frame_tick}, {15'd0, e_tick});
        check_val("load_ready", {15'd0, load_ready}, {15'd0, e_ready});
    endtask

    task automatic idle(input int unsigned cycles);
        logic acc;
        for (int i = 0; i < cycles; i++) step(1'b0, 16'h0000, acc);
    endtask

    task automatic load_frame(input logic [15:0] d);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 4 * FRAME && !acc; i++) step(1'b1, d, acc);
        if (!acc) check_val("load_timeout", 16'd0, 16'd1);
    endtask

    initial begin
        logic        acc;
        logic        rv;
        logic [15:0] rd;
        dec_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
        rst_n      = 1'b1;
        load_valid = 1'b0;
        digits_in  = 16'h0000;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_an", {12'd0, an}, 16'h000F);
        check_val("rst_seg", {9'd0, seg}, 16'h007F);
        check_val("rst_tick", {15'd0, frame_tick}, 16'h0000);
        check_val("rst_ready", {15'd0, load_ready}, 16'h0001);
        @(negedge clk);
        rst_n = 1'b1;

        idle(2 * FRAME + 3);
        load_frame(16'h0705);
        idle(2 * FRAME);

        load_frame(16'h1234);
        load_frame(16'h5678);
        idle(2 * FRAME);

        for (int i = 0; i < FRAME && (mdl_n % FRAME) != FRAME - 1; i++) idle(1);
        step(1'b1, 16'h4321, acc);
        idle(2 * FRAME + 2);

        load_frame(16'h00C0);
        idle(2 * FRAME);
        load_frame(16'h0042);
        idle(2 * FRAME);
        load_frame(16'h0000);
        idle(2 * FRAME);

        rv = 1'b0;
        rd = 16'h0000;
        for (int i = 0; i < 1500; i++) begin
            if (!(rv && load_valid && !load_ready)) begin
                rv = ($urandom_range(0, 3) == 0);
                rd = 16'($urandom) >> (4 * $urandom_range(0, 3));
            end
            step(rv, rd, acc);
        end

        load_frame(16'h9876);
        idle(2 * FRAME);
        for (int i = 0; i < FRAME && (mdl_n % FRAME) != 9; i++) idle(1);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_an", {12'd0, an}, 16'h000F);
        check_val("midrst_seg", {9'd0, seg}, 16'h007F);
        check_val("midrst_tick", {15'd0, frame_tick}, 16'h0000);
        check_val("midrst_ready", {15'd0, load_ready}, 16'h0001);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle(2 * FRAME);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_controller.md
Name: seven_seg_scan_controller

Overview:
- Time-multiplexes a 4-digit common-anode 7-segment display from four BCD digits. Sequential counterpart of the combinational display path: the BCD decoder output feeds it through a valid/ready load port.
- Owns the refresh timer, the digit rotation, anti-ghosting blanking and tear-free frame updates.
- Drives the board's seg/an pins directly.

Parameters:
- REFRESH_DIV, 50000, clock cycles per digit slot (>= 2); 1 kHz/digit at 50 MHz.
- BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off (0 <= BLANK_CYCLES < REFRESH_DIV).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; active-low, asynchronous assert
- load_valid  in  1  digits_in holds a new frame
- load_ready  out  1  controller can accept a frame
- digits_in  in  16  {d3,d2,d1,d0} BCD nibbles; d0 is the rightmost digit (an[0])
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- an  out  4  anode enables, active-low, one-hot-low when lit
- frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (async, rst_n=0):
  - slot counter=0, digit index=0
  - display register=0, pending register empty, load_ready=1
  - an=4'b1111, seg=7'b1111111, frame_tick=0
- Slot counter counts 0..REFRESH_DIV-1 and wraps. On wrap, digit index advances 0→1→2→3→0.
- Outputs are registered: seg/an reflect counter/index state with 1-cycle latency.
- Blanking: while the counter is < BLANK_CYCLES, an=4'b1111 and seg=7'b1111111. Otherwise an[idx]=0, other anodes=1, seg=decode(display[idx]).
- Decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - nibble 10–15 shows "-" = 0111111
- Handshake:
  - Transfer occurs when load_valid && load_ready at a clk edge; digits_in is captured into the pending register.
  - load_ready = !pending_full. It falls the cycle after acceptance.
  - Producer must hold digits_in stable while load_valid=1 && load_ready=0.
- Frame commit: on the cycle where idx==3 and counter==REFRESH_DIV-1:
  - frame_tick=1.
  - If pending is full: display register <= pending, pending cleared, load_ready=1 next cycle.
- Simultaneous events:
  - A transfer accepted on the commit cycle (pending was empty) is not bypassed. It commits at the next frame boundary.
  - Commit and a new load cannot coincide with pending full, because load_ready=0.
- The display never changes mid-frame: all four digits shown in one frame come from the same committed value.
- Reset mid-frame: outputs go dark immediately (async). Pending and display content are lost. Scanning restarts at digit 0, count 0 after rst_n releases.
- No other state: no FSM beyond the counter/index pair and the pending flag.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined:
  - Zero digits above the most significant non-zero digit are suppressed: an stays 4'b1111 for that slot and seg=7'b1111111.
  - Digit 0 is always shown, so value 0000 displays "0".
  - Suppression is computed from the committed display register.
- When undefined: all four digits are always lit, including leading zeros.

Test Plan:
- Reset and rotation (REFRESH_DIV=4, BLANK_CYCLES=1): after rst_n release, an sequence per slot is 1111,1110,1110,1110 then 1111,1101,... → a full frame takes 16 cycles and frame_tick pulses once every 16 cycles.
- Load 16'h0705 while idle → load_ready drops 1 cycle after transfer. At the next frame_tick the display updates, with digit0 seg=0010010 and digit2 seg=1111000. load_ready returns to 1 the following cycle.
- Back-to-back: load 16'h1234, then hold load_valid with 16'h5678 → second load stalls (load_ready=0) until commit. The frame shows 1234 for one complete frame, then 5678 after the next boundary, with no mixed frame.
- Load accepted exactly on the frame_tick cycle → value appears only after the following frame_tick, not the current one.
- Nibble 4'hC in d1 → digit1 seg=0111111.
- Assert rst_n=0 mid-slot of digit 2 → an=1111 and seg=1111111 within the same cycle, with no clock edge required. Display register reads 0000 after release. With LEADING_ZERO_BLANK_EN, display 16'h0042 lights only an[1] and an[0] slots, and 16'h0000 lights only an[0] showing 1000000.
